// File: rtl/aoi221_chk_pkg.sv
// Shared definitions for the AOI221 cell checker.
// Contents:
//   chk_state_t  - checker FSM states (IDLE, SETTLE, SAMPLE, FINISH)
//   VEC_W        - width of the vector index (5 cell inputs)
//   NUM_VEC      - number of exhaustive input vectors (32)
//   ERR_W        - width of the mismatch counter (must hold 0..32)
//   stim_t       - the five stimulus pins of the cell under test
//   vec_to_stim  - maps a vector index onto the cell pins
package aoi221_chk_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      FINISH
   } chk_state_t;

   localparam int VEC_W   = 5;
   localparam int NUM_VEC = 32;
   localparam int ERR_W   = 6;

   typedef struct packed {
      logic a;
      logic b1;
      logic b2;
      logic c1;
      logic c2;
   } stim_t;

   // The MSB of the index drives A so that the A=0 half of the truth
   // table (where the cell can ever output 1) is visited first.
   function automatic stim_t vec_to_stim(input logic [VEC_W-1:0] vec);
      stim_t s;
      s.a  = vec[4];
      s.b1 = vec[3];
      s.b2 = vec[2];
      s.c1 = vec[1];
      s.c2 = vec[0];
      return s;
   endfunction

endpackage

// File: rtl/aoi221_ref_model.sv
// Combinational reference model of a fault-free AOI221 cell.
// Ports:
//   vec    in  [VEC_W-1:0]  vector index, pin mapping as in vec_to_stim
//   exp_zn out 1            expected ZN = ~(A | B1&B2 | C1&C2)
module aoi221_ref_model
   import aoi221_chk_pkg::*;
(
   input  logic [VEC_W-1:0] vec,
   output logic             exp_zn
);

   assign exp_zn = ~(vec[4] | (vec[3] & vec[2]) | (vec[1] & vec[0]));

endmodule

// File: rtl/aoi221_cell_checker.sv
// Exhaustive stimulus generator and response checker for one AOI221 cell.
// Each of the 32 input vectors is held for SETTLE_CYCLES + 1 cycles and
// ZN is compared against the reference model in the last held cycle.
// Ports:
//   CK          in   clock, rising edge
//   RST         in   synchronous active-high reset
//   START       in   start a 32-vector run (only honoured in IDLE)
//   ZN          in   output of the cell under test (same clock domain)
//   A,B1,B2,C1,C2 out registered stimulus to the cell
//   BUSY        out  run in progress
//   DONE        out  one-cycle end-of-run pulse
//   PASS        out  last completed run had no mismatches
//   ERR_CNT     out  mismatch count of current/last run
//   FAIL_VALID  out  at least one mismatch recorded
//   FAIL_VEC    out  index of first mismatching vector
module aoi221_cell_checker
   import aoi221_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             START,
   input  logic             ZN,
   output logic             A,
   output logic             B1,
   output logic             B2,
   output logic             C1,
   output logic             C2,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic             FAIL_VALID,
   output logic [VEC_W-1:0] FAIL_VEC
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

   chk_state_t       state;
   chk_state_t       state_nxt;
   logic [VEC_W-1:0] vec;
   logic [3:0]       settle_cnt;
   stim_t            stim_q;
   logic             exp_zn;
   logic             mismatch;
   logic             settle_done;
   logic             last_vec;

   aoi221_ref_model u_ref_model (
      .vec    (vec),
      .exp_zn (exp_zn)
   );

   assign mismatch    = (ZN != exp_zn);
   assign settle_done = (settle_cnt == SETTLE_LAST);
   assign last_vec    = (vec == LAST_VEC);

   always_ff @(posedge CK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (START) state_nxt = SETTLE;
         SETTLE:  if (settle_done) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = last_vec ? FINISH : SETTLE;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Vector/settle counters, stimulus register and result registers.
   // PASS is resolved at the final compare edge so that it is already
   // valid in the DONE cycle alongside the final ERR_CNT.
   always_ff @(posedge CK) begin
      if (RST) begin
         vec        <= '0;
         settle_cnt <= '0;
         stim_q     <= '0;
         ERR_CNT    <= '0;
         FAIL_VALID <= 1'b0;
         FAIL_VEC   <= '0;
         PASS       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  vec        <= '0;
                  settle_cnt <= '0;
                  stim_q     <= vec_to_stim('0);
                  ERR_CNT    <= '0;
                  FAIL_VALID <= 1'b0;
                  FAIL_VEC   <= '0;
                  PASS       <= 1'b0;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_done ? 4'd0 : settle_cnt + 4'd1;
            end
            SAMPLE: begin
               if (mismatch) begin
                  ERR_CNT <= ERR_CNT + ERR_W'(1);
                  if (!FAIL_VALID) begin
                     FAIL_VALID <= 1'b1;
                     FAIL_VEC   <= vec;
                  end
               end
               if (last_vec) begin
                  stim_q <= '0;
                  PASS   <= (ERR_CNT == '0) && !mismatch;
               end else begin
                  vec    <= vec + 1'b1;
                  stim_q <= vec_to_stim(vec + 1'b1);
               end
            end
            FINISH: begin
               vec    <= '0;
               stim_q <= '0;
            end
            default: begin
               stim_q <= '0;
            end
         endcase
      end
   end

   assign A  = stim_q.a;
   assign B1 = stim_q.b1;
   assign B2 = stim_q.b2;
   assign C1 = stim_q.c1;
   assign C2 = stim_q.c2;

   assign BUSY = (state == SETTLE) || (state == SAMPLE);
   assign DONE = (state == FINISH);

endmodule

// File: tb/tb_aoi221_cell_checker.sv
// Directed testbench for aoi221_cell_checker.
// dut1 (SETTLE_CYCLES=2) is driven by a selectable cell model: correct,
// ZN stuck at 0, ZN stuck at 1, or a cell that ignores A.
// dut2 (SETTLE_CYCLES=1) sees a correct cell with START held high.
module tb_aoi221_cell_checker;

   logic       CK = 1'b0;
   logic       RST;
   logic       start1;
   logic       start2;
   logic [1:0] mode;

   logic [4:0] pins1;
   logic       zn1;
   logic       busy1, done1, pass1, fv1;
   logic [5:0] err1;
   logic [4:0] fvec1;

   logic [4:0] pins2;
   logic       zn2;
   logic       busy2, done2, pass2, fv2;
   logic [5:0] err2;
   logic [4:0] fvec2;

   int checks   = 0;
   int failures = 0;

   always #5 CK = ~CK;

   // Cell under test models; pins are {A,B1,B2,C1,C2}.
   always_comb begin
      zn1 = ~(pins1[4] | (pins1[3] & pins1[2]) | (pins1[1] & pins1[0]));
      case (mode)
         2'd1: zn1 = 1'b0;
         2'd2: zn1 = 1'b1;
         2'd3: zn1 = ~((pins1[3] & pins1[2]) | (pins1[1] & pins1[0]));
         default: ;
      endcase
   end

   assign zn2 = ~(pins2[4] | (pins2[3] & pins2[2]) | (pins2[1] & pins2[0]));

   aoi221_cell_checker #(.SETTLE_CYCLES(2)) dut1 (
      .CK         (CK),
      .RST        (RST),
      .START      (start1),
      .ZN         (zn1),
      .A          (pins1[4]),
      .B1         (pins1[3]),
      .B2         (pins1[2]),
      .C1         (pins1[1]),
      .C2         (pins1[0]),
      .BUSY       (busy1),
      .DONE       (done1),
      .PASS       (pass1),
      .ERR_CNT    (err1),
      .FAIL_VALID (fv1),
      .FAIL_VEC   (fvec1)
   );

   aoi221_cell_checker #(.SETTLE_CYCLES(1)) dut2 (
      .CK         (CK),
      .RST        (RST),
      .START      (start2),
      .ZN         (zn2),
      .A          (pins2[4]),
      .B1         (pins2[3]),
      .B2         (pins2[2]),
      .C1         (pins2[1]),
      .C2         (pins2[0]),
      .BUSY       (busy2),
      .DONE       (done2),
      .PASS       (pass2),
      .ERR_CNT    (err2),
      .FAIL_VALID (fv2),
      .FAIL_VEC   (fvec2)
   );

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_dut1_idle_zero(input string tag);
      check_output({tag, "_pins"}, 32'(pins1), 0);
      check_output({tag, "_busy"}, 32'(busy1), 0);
      check_output({tag, "_done"}, 32'(done1), 0);
      check_output({tag, "_pass"}, 32'(pass1), 0);
      check_output({tag, "_err"},  32'(err1),  0);
      check_output({tag, "_fv"},   32'(fv1),   0);
      check_output({tag, "_fvec"}, 32'(fvec1), 0);
   endtask

   // Full dut1 run: START accepted at the next edge (edge 0), vector k/3
   // expected after edge k, DONE after edge 96.
   task automatic run_dut1(input string tag, input int exp_err,
                           input logic exp_fv, input int exp_fvec,
                           input logic exp_pass);
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      check_output({tag, "_busy0"}, 32'(busy1), 1);
      check_output({tag, "_err0"},  32'(err1),  0);
      check_output({tag, "_pass0"}, 32'(pass1), 0);
      check_output({tag, "_pins0"}, 32'(pins1), 0);
      for (int k = 1; k < 96; k++) begin
         step();
         check_output($sformatf("%s_pins_e%0d", tag, k), 32'(pins1), k / 3);
         check_output($sformatf("%s_busy_e%0d", tag, k), 32'(busy1), 1);
      end
      step();
      check_output({tag, "_done96"}, 32'(done1), 1);
      check_output({tag, "_busy96"}, 32'(busy1), 0);
      check_output({tag, "_pins96"}, 32'(pins1), 0);
      check_output({tag, "_err"},    32'(err1),  32'(exp_err));
      check_output({tag, "_fv"},     32'(fv1),   32'(exp_fv));
      if (exp_fv) check_output({tag, "_fvec"}, 32'(fvec1), 32'(exp_fvec));
      check_output({tag, "_pass"},   32'(pass1), 32'(exp_pass));
      step();
      check_output({tag, "_done97"}, 32'(done1), 0);
      check_output({tag, "_pass97"}, 32'(pass1), 32'(exp_pass));
      check_output({tag, "_err97"},  32'(err1),  32'(exp_err));
   endtask

   // dut2 run with START already high: vector k/2 after edge k, DONE
   // after edge 64.
   task automatic run_dut2(input string tag);
      for (int k = 0; k < 64; k++) begin
         step();
         check_output($sformatf("%s_pins_e%0d", tag, k), 32'(pins2), k / 2);
         check_output($sformatf("%s_busy_e%0d", tag, k), 32'(busy2), 1);
         if (k == 0) check_output({tag, "_pass0"}, 32'(pass2), 0);
      end
      step();
      check_output({tag, "_done64"}, 32'(done2), 1);
      check_output({tag, "_pass64"}, 32'(pass2), 1);
      check_output({tag, "_err64"},  32'(err2),  0);
      check_output({tag, "_fv64"},   32'(fv2),   0);
   endtask

   initial begin
      RST    = 1'b1;
      start1 = 1'b0;
      start2 = 1'b0;
      mode   = 2'd0;

      step();
      step();
      check_dut1_idle_zero("rst");
      RST = 1'b0;
      step();
      check_dut1_idle_zero("post_rst");

      mode = 2'd0;
      run_dut1("good", 0, 1'b0, 0, 1'b1);
      mode = 2'd1;
      run_dut1("stuck0", 9, 1'b1, 0, 1'b0);
      mode = 2'd2;
      run_dut1("stuck1", 23, 1'b1, 3, 1'b0);
      mode = 2'd3;
      run_dut1("ignore_a", 9, 1'b1, 16, 1'b0);

      // Mid-run reset: stuck-at-0 cell so results are non-zero before RST.
      mode   = 2'd1;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      repeat (9) step();
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      check_output("mid_busy_e10", 32'(busy1), 1);
      check_output("mid_pins_e10", 32'(pins1), 3);
      repeat (29) step();
      check_output("mid_pins_e39", 32'(pins1), 13);
      step();
      check_output("mid_err_e40",  32'(err1),  9);
      check_output("mid_fv_e40",   32'(fv1),   1);
      RST = 1'b1;
      step();
      check_dut1_idle_zero("mid_rst_e41");
      RST  = 1'b0;
      mode = 2'd0;
      step();
      check_output("mid_idle_e42", 32'(busy1), 0);
      repeat (7) step();
      run_dut1("after_rst", 0, 1'b0, 0, 1'b1);

      // Back-to-back runs with START held high.
      start2 = 1'b1;
      run_dut2("b2b1");
      step();
      check_output("b2b_done65", 32'(done2), 0);
      check_output("b2b_busy65", 32'(busy2), 0);
      run_dut2("b2b2");
      start2 = 1'b0;
      step();
      check_output("b2b_done_end", 32'(done2), 0);
      step();
      check_output("b2b_idle_end", 32'(busy2), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aoi221_cell_checker.md
# aoi221_cell_checker

Synchronous stimulus generator and response checker for a single AOI221 cell instance, where ZN = ~(A | (B1 & B2) | (C1 & C2)). It drives the cell's five inputs through all 32 combinations and samples ZN after a programmable settle interval. It compares each sample against a built-in reference model and reports the pass/fail result, the mismatch count and the first failing vector. It sits beside the cell under test in the library silicon/netlist characterization harness, as the driving and observing end of the cell's pin interface.

## Interface
- SETTLE_CYCLES, 2, number of cycles a vector is held before ZN is sampled. Legal range 1..15.
- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  begin a 32-vector run. Sampled only in IDLE.
- ZN  in  1  output of the cell under test.
- A, B1, B2, C1, C2  out  1 each  registered stimulus to the cell under test.
- BUSY  out  1  high from the START-accept edge until FINISH is entered.
- DONE  out  1  one-cycle pulse in FINISH.
- PASS  out  1  high when the last completed run had zero mismatches. Held until the next START or RST.
- ERR_CNT  out  6  number of mismatches in the current or last run (0..32).
- FAIL_VALID  out  1  at least one mismatch recorded in the current or last run.
- FAIL_VEC  out  5  index of the first mismatching vector. Valid only when FAIL_VALID=1.

## Operation
- Vector index vec[4:0] maps to pins as A=vec[4], B1=vec[3], B2=vec[2], C1=vec[1], C2=vec[0]. Vectors run in order 0..31.
- Expected value: exp = ~(vec[4] | (vec[3]&vec[2]) | (vec[1]&vec[0])). A correct cell gives exp=1 for 9 vectors and exp=0 for 23 vectors.
- States:
  - IDLE: stimulus = 0, BUSY = 0. When START=1: load vec=0, clear ERR_CNT, FAIL_VALID, FAIL_VEC and PASS, set BUSY, go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: compare ZN with exp. On mismatch, ERR_CNT += 1; if FAIL_VALID=0, set FAIL_VALID=1 and FAIL_VEC=vec. If vec==31, go to FINISH; otherwise vec += 1 and go to SETTLE.
  - FINISH: DONE=1, BUSY=0, PASS = (ERR_CNT==0), stimulus returns to 0, next state IDLE.
- Counter widths:
  - ERR_CNT is 6 bits and never wraps, since the maximum count is 32.
  - The settle counter is 4 bits.
- START while not in IDLE is ignored, including in FINISH. START held high in the cycle after FINISH starts a new run.
- RST has priority over everything, including mid-run. On the next edge: state=IDLE, all outputs 0, vec=0, settle counter=0.
- ZN is used raw, with no synchronizer, because the cell is in the same clock domain. The bench must never drive ZN to X or Z.

## Timing
- Reset value of every output is 0.
- Edge 0 is the edge at which START is accepted. Vector v is driven from edge v·(SETTLE_CYCLES+1) to edge (v+1)·(SETTLE_CYCLES+1).
- ZN for vector v is compared at edge (v+1)·(SETTLE_CYCLES+1), i.e. in the last cycle that vector v is held.
- DONE is high in the cycle after edge 32·(SETTLE_CYCLES+1). For the default setting this is edge 96.
- A new run can start, at the earliest, at the edge following the DONE cycle.
- ERR_CNT and FAIL_* update one edge after the compare. They are stable while DONE is high.

## Structure
- Package aoi221_chk_pkg contains:
  - the state enum (IDLE, SETTLE, SAMPLE, FINISH);
  - VEC_W=5, NUM_VEC=32, ERR_W=6;
  - the pin-mapping function from vec to the stimulus bits.
- Sub-module aoi221_ref_model is the combinational expected-ZN model from vec[4:0]. It is reused by the bench scoreboard.
- The top level holds the FSM, the vector counter, the settle counter and the result registers.

## Test plan
- Correct cell model, SETTLE_CYCLES=2 → DONE at edge 96, PASS=1, ERR_CNT=0, FAIL_VALID=0. The stimulus sequence is monitored to be 0..31, each vector held 3 cycles.
- ZN stuck at 0 → ERR_CNT=9, FAIL_VEC=0, PASS=0.
- ZN stuck at 1 → ERR_CNT=23, FAIL_VEC=3, PASS=0.
- Faulty cell that ignores A, i.e. ZN=~(B1B2|C1C2) → ERR_CNT=9, FAIL_VEC=16.
- RST asserted at edge 40 of a run, with START pulsed at edges 10 and 50 → the edge-10 pulse is ignored while BUSY. After edge 41, all outputs are 0 and state is IDLE. The edge-50 pulse starts a fresh run that ends PASS=1.
- SETTLE_CYCLES=1 with a correct cell, START held high continuously → DONE at edge 64, then back-to-back runs with no lost vectors.
